// File: rtl/sys_bus_dmem_responder_if.sv
// System data bus between the core (master) and the data-memory responder
// (slave). The core presents one access per cycle during EX; the responder
// returns registered read data and an error pulse during MEM.
interface sys_bus_dmem_responder_if #(
  parameter int CPU_WIDTH = 32,
  parameter int ACC_W     = 3
);
  logic [CPU_WIDTH-1:0] sys_bus_addr_i;
  logic [ACC_W-1:0]     sys_bus_access_type_i;
  logic [CPU_WIDTH-1:0] sys_bus_wdata_i;
  logic [CPU_WIDTH-1:0] sys_bus_rdata_o;
  logic                 bus_err_o;

  modport master (
    output sys_bus_addr_i,
    output sys_bus_access_type_i,
    output sys_bus_wdata_i,
    input  sys_bus_rdata_o,
    input  bus_err_o
  );

  modport slave (
    input  sys_bus_addr_i,
    input  sys_bus_access_type_i,
    input  sys_bus_wdata_i,
    output sys_bus_rdata_o,
    output bus_err_o
  );
endinterface

// File: rtl/sys_bus_dmem_responder.sv
// Responder end of the core's system data bus. Decodes each EX-cycle access
// into a word-addressed data RAM or a 16-byte MMIO block (GPIO, mtime,
// mtimecmp, IRQ status). Writes commit on the EX edge; read data and the
// error flag are registered and valid during MEM. Sub-word reads come back
// right-justified and zero-extended; the core's WB stage does any sign fill.
module sys_bus_dmem_responder #(
  parameter int                   CPU_WIDTH = 32,
  parameter int                   ACC_W     = 3,
  parameter int                   DMEM_AW   = 12,
  parameter logic [CPU_WIDTH-1:0] MMIO_BASE = 32'h1000_0000,
  parameter int                   GPIO_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  sys_bus_dmem_responder_if.slave  bus,
  output logic [GPIO_W-1:0]        gpio_o,
  output logic                     timer_irq_o
);

  localparam int NB = CPU_WIDTH / 8;

  localparam logic [ACC_W-1:0] ACC_RD_B = ACC_W'(1);
  localparam logic [ACC_W-1:0] ACC_RD_H = ACC_W'(2);
  localparam logic [ACC_W-1:0] ACC_RD_W = ACC_W'(3);
  localparam logic [ACC_W-1:0] ACC_WR_B = ACC_W'(4);
  localparam logic [ACC_W-1:0] ACC_WR_H = ACC_W'(5);
  localparam logic [ACC_W-1:0] ACC_WR_W = ACC_W'(6);

  localparam logic [1:0] REG_GPIO   = 2'd0;
  localparam logic [1:0] REG_MTIME  = 2'd1;
  localparam logic [1:0] REG_MTCMP  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  logic [CPU_WIDTH-1:0] mem [0:(1<<DMEM_AW)-1];

  logic [GPIO_W-1:0]    gpio_q;
  logic [CPU_WIDTH-1:0] mtime_q;
  logic [CPU_WIDTH-1:0] mtimecmp_q;
  logic                 status_q;

  logic [CPU_WIDTH-1:0] rdata_p1;
  logic                 err_p1;

  // ---- p0: EX-cycle decode of the presented access ----
  logic [ACC_W-1:0]     acc_p0;
  logic [CPU_WIDTH-1:0] addr_p0;
  logic [CPU_WIDTH-1:0] wdata_p0;
  logic                 rd_p0, wr_p0, vld_p0;
  logic                 sz_h_p0, sz_w_p0;
  logic                 in_ram_p0, in_mmio_p0, misal_p0, err_p0;
  logic [1:0]           reg_sel_p0;
  logic [DMEM_AW-1:0]   ram_idx_p0;
  logic                 ram_we_p0, mmio_we_p0;
  logic [NB-1:0]        be_p0;
  logic [CPU_WIDTH-1:0] wlane_p0;
  logic [CPU_WIDTH-1:0] ram_word_p0, ram_sh_p0, ram_rd_p0, mmio_rd_p0, rd_val_p0;
  logic                 sts_clr_p0, match_p0;

  assign acc_p0   = bus.sys_bus_access_type_i;
  assign addr_p0  = bus.sys_bus_addr_i;
  assign wdata_p0 = bus.sys_bus_wdata_i;

  // Classify access type into direction and size; reserved codes act as NONE.
  always_comb begin
    rd_p0   = 1'b0;
    wr_p0   = 1'b0;
    sz_h_p0 = 1'b0;
    sz_w_p0 = 1'b0;
    case (acc_p0)
      ACC_RD_B: rd_p0 = 1'b1;
      ACC_RD_H: begin rd_p0 = 1'b1; sz_h_p0 = 1'b1; end
      ACC_RD_W: begin rd_p0 = 1'b1; sz_w_p0 = 1'b1; end
      ACC_WR_B: wr_p0 = 1'b1;
      ACC_WR_H: begin wr_p0 = 1'b1; sz_h_p0 = 1'b1; end
      ACC_WR_W: begin wr_p0 = 1'b1; sz_w_p0 = 1'b1; end
      default: ;
    endcase
  end

  assign vld_p0     = rd_p0 | wr_p0;
  assign in_ram_p0  = (addr_p0[CPU_WIDTH-1:DMEM_AW+2] == '0);
  assign in_mmio_p0 = (addr_p0[CPU_WIDTH-1:4] == MMIO_BASE[CPU_WIDTH-1:4]);
  assign misal_p0   = (sz_h_p0 & addr_p0[0]) | (sz_w_p0 & (addr_p0[1:0] != 2'b00));
  assign reg_sel_p0 = addr_p0[3:2];
  assign ram_idx_p0 = addr_p0[DMEM_AW+1:2];

  // MTIME is read-only and MMIO only takes whole words.
  assign err_p0 = vld_p0 & ( ~(in_ram_p0 | in_mmio_p0)
                           | misal_p0
                           | (in_mmio_p0 & ~sz_w_p0)
                           | (in_mmio_p0 & wr_p0 & (reg_sel_p0 == REG_MTIME)) );

  assign ram_we_p0  = wr_p0 & in_ram_p0  & ~err_p0;
  assign mmio_we_p0 = wr_p0 & in_mmio_p0 & ~err_p0;
  assign sts_clr_p0 = mmio_we_p0 & (reg_sel_p0 == REG_STATUS) & wdata_p0[0];
  assign match_p0   = (mtime_q == mtimecmp_q);

  // Byte enables and lane-replicated store data for the RAM write port.
  always_comb begin
    be_p0    = '0;
    wlane_p0 = wdata_p0;
    if (ram_we_p0) begin
      if (sz_w_p0) begin
        be_p0 = '1;
      end else if (sz_h_p0) begin
        be_p0    = NB'(3) << {addr_p0[1], 1'b0};
        wlane_p0 = {(NB/2){wdata_p0[15:0]}};
      end else begin
        be_p0    = NB'(1) << addr_p0[1:0];
        wlane_p0 = {NB{wdata_p0[7:0]}};
      end
    end
  end

  // RAM read path: shift the addressed lane(s) down to bit 0 and zero the rest.
  always_comb begin
    ram_word_p0 = mem[ram_idx_p0];
    ram_sh_p0   = ram_word_p0 >> {addr_p0[1:0], 3'b000};
    if (sz_w_p0)
      ram_rd_p0 = ram_word_p0;
    else if (sz_h_p0)
      ram_rd_p0 = {{(CPU_WIDTH-16){1'b0}}, ram_sh_p0[15:0]};
    else
      ram_rd_p0 = {{(CPU_WIDTH-8){1'b0}}, ram_sh_p0[7:0]};
  end

  // MMIO read mux; MTIME returns the value before this edge's increment.
  always_comb begin
    mmio_rd_p0 = '0;
    case (reg_sel_p0)
      REG_GPIO:   mmio_rd_p0 = {{(CPU_WIDTH-GPIO_W){1'b0}}, gpio_q};
      REG_MTIME:  mmio_rd_p0 = mtime_q;
      REG_MTCMP:  mmio_rd_p0 = mtimecmp_q;
      REG_STATUS: mmio_rd_p0 = {{(CPU_WIDTH-1){1'b0}}, status_q};
      default: ;
    endcase
  end

  assign rd_val_p0 = in_ram_p0 ? ram_rd_p0 : mmio_rd_p0;

  // RAM write port: per-lane commit on the EX edge, contents survive reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (be_p0[i]) mem[ram_idx_p0][8*i +: 8] <= wlane_p0[8*i +: 8];
    end
  end

  // MMIO registers and timer; mtime and the IRQ match run every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_q     <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      status_q   <= 1'b0;
    end else begin
      mtime_q <= mtime_q + 1'b1;
      if (mmio_we_p0 && reg_sel_p0 == REG_GPIO)  gpio_q     <= wdata_p0[GPIO_W-1:0];
      if (mmio_we_p0 && reg_sel_p0 == REG_MTCMP) mtimecmp_q <= wdata_p0;
      // A match in the same cycle as a W1C clear wins.
      if (match_p0)        status_q <= 1'b1;
      else if (sts_clr_p0) status_q <= 1'b0;
    end
  end

  // ---- p1: MEM-cycle registered response ----
  // Read data is zero on errors and on cycles without a read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_p1 <= '0;
      err_p1   <= 1'b0;
    end else begin
      rdata_p1 <= (rd_p0 && !err_p0) ? rd_val_p0 : '0;
      err_p1   <= err_p0;
    end
  end

  assign bus.sys_bus_rdata_o = rdata_p1;
  assign bus.bus_err_o       = err_p1;
  assign gpio_o              = gpio_q;
  assign timer_irq_o         = status_q;

endmodule

// File: tb/tb_sys_bus_dmem_responder.sv
// Bench for sys_bus_dmem_responder: directed accesses push their expected
// MEM-cycle response into a queue; a monitor pops and compares one entry per
// cycle, and flags any response on cycles where no access was issued.
module tb_sys_bus_dmem_responder;

  localparam logic [31:0] M = 32'h1000_0000;
  localparam logic [2:0] NONE = 3'd0, RD_B = 3'd1, RD_H = 3'd2, RD_W = 3'd3,
                         WR_B = 3'd4, WR_H = 3'd5, WR_W = 3'd6, RSV = 3'd7;

  typedef struct {
    string       nm;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  gpio;
  logic        irq;
  logic [31:0] cyc;
  int          total = 0;
  int          bad = 0;
  exp_t        sb[$];
  exp_t        mon_e;

  sys_bus_dmem_responder_if #(.CPU_WIDTH(32), .ACC_W(3)) bus ();

  sys_bus_dmem_responder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .gpio_o      (gpio),
    .timer_irq_o (irq)
  );

  always #5 clk = ~clk;

  // Edges since reset release; equals mtime when sampled at a negedge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 32'd0;
    else        cyc <= cyc + 32'd1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] t, input logic [31:0] a, input logic [31:0] wd);
    bus.sys_bus_access_type_i = t;
    bus.sys_bus_addr_i        = a;
    bus.sys_bus_wdata_i       = wd;
  endtask

  task automatic acc(input logic [2:0] t, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] erd, input logic eerr, input string nm);
    exp_t e;
    @(negedge clk);
    drive(t, a, wd);
    e.nm = nm; e.rd = erd; e.err = eerr;
    sb.push_back(e);
  endtask

  // MTIME read whose expected value is the edge count at issue time.
  task automatic rd_mtime(input string nm);
    exp_t e;
    @(negedge clk);
    drive(RD_W, M + 32'h4, 32'h0);
    e.nm = nm; e.rd = cyc; e.err = 1'b0;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      drive(NONE, 32'h0, 32'h0);
    end
  endtask

  // Monitor: one response per cycle, compared against the queued expectation.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk({mon_e.nm, ".rdata"}, bus.sys_bus_rdata_o, mon_e.rd);
        chk({mon_e.nm, ".err"}, {31'b0, bus.bus_err_o}, {31'b0, mon_e.err});
      end else begin
        chk("idle.rdata", bus.sys_bus_rdata_o, 32'h0);
        chk("idle.err", {31'b0, bus.bus_err_o}, 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    drive(NONE, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    chk("rst.gpio", {24'b0, gpio}, 32'h0);
    chk("rst.irq", {31'b0, irq}, 32'h0);
    chk("rst.rdata", bus.sys_bus_rdata_o, 32'h0);
    chk("rst.err", {31'b0, bus.bus_err_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Timer compare and IRQ status
    acc(WR_W, M + 32'h8, 32'd5, 32'h0, 1'b0, "wr_cmp5");
    idle(4);
    chk("irq_before_match", {31'b0, irq}, 32'h0);
    idle(1);
    chk("irq_after_match", {31'b0, irq}, 32'h1);
    acc(WR_W, M + 32'hC, 32'h1, 32'h0, 1'b0, "w1c");
    idle(1);
    chk("irq_cleared", {31'b0, irq}, 32'h0);
    acc(WR_W, M + 32'h8, 32'd12, 32'h0, 1'b0, "wr_cmp12");
    idle(2);
    chk("irq_wait12", {31'b0, irq}, 32'h0);
    acc(WR_W, M + 32'hC, 32'h1, 32'h0, 1'b0, "w1c_at_match");
    idle(1);
    chk("set_beats_clr", {31'b0, irq}, 32'h1);
    acc(RD_W, M + 32'hC, 32'h0, 32'h1, 1'b0, "rd_status");
    acc(RD_W, M + 32'h8, 32'h0, 32'd12, 1'b0, "rd_cmp");

    // GPIO and MMIO error cases
    acc(WR_W, M, 32'h1FF, 32'h0, 1'b0, "wr_gpio");
    idle(1);
    chk("gpio_ff", {24'b0, gpio}, 32'hFF);
    acc(RD_W, M, 32'h0, 32'hFF, 1'b0, "rd_gpio");
    acc(WR_B, M, 32'h00, 32'h0, 1'b1, "wrb_gpio");
    idle(1);
    chk("gpio_kept", {24'b0, gpio}, 32'hFF);
    acc(RD_H, M, 32'h0, 32'h0, 1'b1, "rdh_gpio");
    acc(WR_W, M + 32'h4, 32'h0, 32'h0, 1'b1, "wr_mtime");
    rd_mtime("mtime_kept");
    acc(RD_W, M + 32'h10, 32'h0, 32'h0, 1'b1, "past_mmio");

    // RAM sub-word access
    acc(WR_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "ww10");
    acc(RD_B, 32'h11, 32'h0, 32'h000000BE, 1'b0, "rb11");
    acc(RD_H, 32'h12, 32'h0, 32'h0000DEAD, 1'b0, "rh12");
    acc(RD_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "rw10");
    acc(RD_B, 32'h13, 32'h0, 32'h000000DE, 1'b0, "rb13");
    acc(WR_B, 32'h13, 32'h12, 32'h0, 1'b0, "wb13");
    acc(RD_W, 32'h10, 32'h0, 32'h12ADBEEF, 1'b0, "rw10_b");
    acc(WR_H, 32'h10, 32'h5555, 32'h0, 1'b0, "wh10");
    acc(RD_W, 32'h10, 32'h0, 32'h12AD5555, 1'b0, "rw10_h");
    acc(WR_W, 32'h14, 32'h0, 32'h0, 1'b0, "ww14");
    acc(WR_B, 32'h15, 32'hFFFFFF3C, 32'h0, 1'b0, "wb15");
    acc(RD_W, 32'h14, 32'h0, 32'h00003C00, 1'b0, "rw14");

    // Misaligned, unmapped and reserved accesses
    acc(WR_W, 32'h20, 32'h11223344, 32'h0, 1'b0, "ww20");
    acc(RD_H, 32'h21, 32'h0, 32'h0, 1'b1, "rh21");
    acc(WR_W, 32'h22, 32'hAAAAAAAA, 32'h0, 1'b1, "ww22");
    acc(WR_H, 32'h23, 32'hBBBB, 32'h0, 1'b1, "wh23");
    acc(WR_W, 32'h2000_0000, 32'hCCCCCCCC, 32'h0, 1'b1, "ww_unmap");
    acc(RD_W, 32'h2000_0000, 32'h0, 32'h0, 1'b1, "rw_unmap");
    acc(RD_W, 32'h4000, 32'h0, 32'h0, 1'b1, "rw_ram_end");
    acc(RSV, 32'h20, 32'h0, 32'h0, 1'b0, "reserved");
    acc(RD_W, 32'h20, 32'h0, 32'h11223344, 1'b0, "rw20_kept");

    // Mid-run reset with gpio=0xA5, mtime=0x40, irq set and rdata non-zero
    acc(WR_W, M, 32'hA5, 32'h0, 1'b0, "wr_gpio_a5");
    while (cyc < 32'd62) idle(1);
    acc(RD_W, 32'h10, 32'h0, 32'h12AD5555, 1'b0, "rw10_pre_rst");
    @(negedge clk);
    drive(NONE, 32'h0, 32'h0);
    chk("pre_rst.gpio", {24'b0, gpio}, 32'hA5);
    chk("pre_rst.irq", {31'b0, irq}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst.gpio", {24'b0, gpio}, 32'h0);
    chk("mid_rst.rdata", bus.sys_bus_rdata_o, 32'h0);
    chk("mid_rst.irq", {31'b0, irq}, 32'h0);
    chk("mid_rst.err", {31'b0, bus.bus_err_o}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    acc(RD_W, M + 32'h4, 32'h0, 32'd2, 1'b0, "mtime_post_rst");
    acc(RD_W, M + 32'h8, 32'h0, 32'hFFFFFFFF, 1'b0, "cmp_post_rst");
    acc(RD_W, M, 32'h0, 32'h0, 1'b0, "gpio_post_rst");
    acc(RD_W, M + 32'hC, 32'h0, 32'h0, 1'b0, "status_post_rst");
    acc(RD_W, 32'h10, 32'h0, 32'h12AD5555, 1'b0, "ram_post_rst");
    idle(3);
    chk("sb_drained", sb.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
